regfile_checker: RTL and testbench

Synthesizable self-check block for the instruction-level SoC benches. It snoops the CPU writeback port into a shadow register file. After a settle condition is met, it compares up to NUM_CHECKS programmed (register, expected value) entries and reports pass/fail, mismatch count and first-failure details. This generalises single-register, fixed-delay instruction checks to many registers, configurable width, and two wait modes: cycle count or retire count with timeout.

---
 rtl/regfile_checker_pkg.sv | 22 ++
 rtl/regfile_shadow.sv | 32 +++
 rtl/regfile_checker.sv | 229 ++++++++++++++++++++++
 tb/tb_regfile_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_checker_pkg.sv
// Shared types and constants for the register-file self-check block.
package regfile_checker_pkg;

    localparam int unsigned NREGS    = 32;
    localparam int unsigned REG_W    = 5;
    // Check-table values are stored at this width and compared zero-extended.
    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    typedef struct packed {
        logic                en;
        logic [REG_W-1:0]    regno;
        logic [MAX_XLEN-1:0] val;
    } check_entry_t;

endpackage

// File: rtl/regfile_shadow.sv
// Snoop copy of the CPU register file: one write port, x0 held at zero,
// one combinational read port, synchronous clear.
module regfile_shadow
    import regfile_checker_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [REG_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [REG_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata_c
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the registered contents, so a same-cycle write is not visible.
    assign rdata_c = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/regfile_checker.sv
// Shadows CPU writebacks, waits for a settle condition, then walks a
// programmable table of (register, expected value) checks and reports results.
module regfile_checker
    import regfile_checker_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_CHECKS     = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]   cfg_idx,
    input  logic                            cfg_en,
    input  logic [4:0]                      cfg_reg,
    input  logic [XLEN-1:0]                 cfg_val,
    input  logic                            wb_we,
    input  logic [4:0]                      wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    input  logic                            start,
    input  logic                            mode,
    input  logic [CNT_W-1:0]                wait_count,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0] fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
    output logic [4:0]                      first_fail_reg,
    output logic [XLEN-1:0]                 first_fail_actual
);

    localparam int unsigned IDX_W = $clog2(NUM_CHECKS);
    localparam int unsigned FC_W  = $clog2(NUM_CHECKS + 1);

    state_e             state_q;
    state_e             state_d;

    logic               mode_q;
    logic               mode_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   timer_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;

    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic               timeout_d;
    logic [FC_W-1:0]    fail_count_d;
    logic [IDX_W-1:0]   ff_idx_d;
    logic [REG_W-1:0]   ff_reg_d;
    logic [XLEN-1:0]    ff_act_d;

    check_entry_t       chk_tbl [NUM_CHECKS];
    check_entry_t       cur_c;
    logic [XLEN-1:0]    shadow_rd_c;
    logic               mismatch_c;
    logic               last_c;
    logic [CNT_W-1:0]   timer_inc_c;
    logic               wait_done_c;
    logic               timer_hit_c;
    logic               cfg_ok_c;

    regfile_shadow #(
        .XLEN (XLEN)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr   (cur_c.regno),
        .rdata_c (shadow_rd_c)
    );

    assign cur_c       = chk_tbl[idx_q];
    assign mismatch_c  = cur_c.en && (MAX_XLEN'(shadow_rd_c) != cur_c.val);
    assign last_c      = (idx_q == IDX_W'(NUM_CHECKS - 1));
    assign timer_inc_c = timer_q + CNT_W'(1);
    // Retire mode leaves WAIT on the same edge that samples the final writeback.
    assign wait_done_c = (cnt_q == '0) || (mode_q && wb_we && (cnt_q == CNT_W'(1)));
    assign timer_hit_c = mode_q && (timer_inc_c == CNT_W'(TIMEOUT_CYCLES));
    assign cfg_ok_c    = (state_q == IDLE) || (state_q == DONE);

    // Check table is only writable while no run is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                chk_tbl[i] <= '0;
            end
        end else if (cfg_we && cfg_ok_c) begin
            chk_tbl[cfg_idx] <= '{en: cfg_en, regno: cfg_reg, val: MAX_XLEN'(cfg_val)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_done_c) begin
                    state_d = CHECK;
                end else if (timer_hit_c) begin
                    state_d = DONE;
                end
            end
            CHECK: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for datapath counters and registered result outputs.
    always_comb begin
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        busy_d       = busy;
        done_d       = done;
        pass_d       = pass;
        timeout_d    = timeout;
        fail_count_d = fail_count;
        ff_idx_d     = first_fail_idx;
        ff_reg_d     = first_fail_reg;
        ff_act_d     = first_fail_actual;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d       = mode;
                    cnt_d        = wait_count;
                    timer_d      = '0;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_count_d = '0;
                    ff_idx_d     = '0;
                    ff_reg_d     = '0;
                    ff_act_d     = '0;
                end
            end
            WAIT: begin
                timer_d = timer_inc_c;
                if ((!mode_q || wb_we) && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (!wait_done_c && timer_hit_c) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    fail_count_d = fail_count + FC_W'(1);
                    if (fail_count == '0) begin
                        ff_idx_d = idx_q;
                        ff_reg_d = cur_c.regno;
                        ff_act_d = shadow_rd_c;
                    end
                end
                if (last_c) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    pass_d = (fail_count_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q            <= 1'b0;
            cnt_q             <= '0;
            timer_q           <= '0;
            idx_q             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            timeout           <= 1'b0;
            fail_count        <= '0;
            first_fail_idx    <= '0;
            first_fail_reg    <= '0;
            first_fail_actual <= '0;
        end else begin
            mode_q            <= mode_d;
            cnt_q             <= cnt_d;
            timer_q           <= timer_d;
            idx_q             <= idx_d;
            busy              <= busy_d;
            done              <= done_d;
            pass              <= pass_d;
            timeout           <= timeout_d;
            fail_count        <= fail_count_d;
            first_fail_idx    <= ff_idx_d;
            first_fail_reg    <= ff_reg_d;
            first_fail_actual <= ff_act_d;
        end
    end

endmodule

// File: tb/tb_regfile_checker.sv
// Directed bench for regfile_checker with hand-computed expectations.
module tb_regfile_checker;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NCHK    = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [2:0]       cfg_idx;
    logic             cfg_en;
    logic [4:0]       cfg_reg;
    logic [XLEN-1:0]  cfg_val;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] wait_count;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [3:0]       fail_count;
    logic [2:0]       first_fail_idx;
    logic [4:0]       first_fail_reg;
    logic [XLEN-1:0]  first_fail_actual;

    int tests  = 0;
    int failed = 0;

    regfile_checker #(
        .XLEN           (XLEN),
        .NUM_CHECKS     (NCHK),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_we            (cfg_we),
        .cfg_idx           (cfg_idx),
        .cfg_en            (cfg_en),
        .cfg_reg           (cfg_reg),
        .cfg_val           (cfg_val),
        .wb_we             (wb_we),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .start             (start),
        .mode              (mode),
        .wait_count        (wait_count),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timeout           (timeout),
        .fail_count        (fail_count),
        .first_fail_idx    (first_fail_idx),
        .first_fail_reg    (first_fail_reg),
        .first_fail_actual (first_fail_actual)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_we = 1'b1; wb_rd = rd; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic en, input logic [4:0] r, input logic [XLEN-1:0] v);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_reg = r; cfg_val = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic clear_entries();
        for (int i = 0; i < int'(NCHK); i++) cfg(i, 1'b0, 5'd0, '0);
    endtask

    // Pulses start; the start edge is edge k.
    task automatic start_run(input logic m, input int wc);
        mode = m; wait_count = CNT_W'(wc); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after edge k until done, bounded.
    task automatic wait_done(input int bound, inout int n);
        while (!done && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %0b want 0", done); end
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL reset_pass: got %0b want 0", pass); end
        tests++; if (timeout !== 1'b0) begin failed++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        tests++; if (fail_count !== 4'd0) begin failed++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        tests++; if ({first_fail_idx, first_fail_reg, first_fail_actual} !== '0) begin
            failed++; $display("FAIL reset_first_fail: got %0h/%0h/%0h want 0", first_fail_idx, first_fail_reg, first_fail_actual);
        end
    endtask

    task automatic test_single();
        int n = 0;
        wb(5'd7, 32'h0000_000D);
        cfg(0, 1'b1, 5'd7, 32'h0000_000D);
        start_run(1'b0, 3);
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL single_busy_rise: got %0b want 1", busy); end
        wait_done(100, n);
        tests++; if (n !== 12) begin failed++; $display("FAIL single_latency: got %0d want 12", n); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy_fall: got %0b want 0", busy); end
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL single_pass: got %0b want 1", pass); end
        tests++; if (fail_count !== 4'd0) begin failed++; $display("FAIL single_fail_count: got %0d want 0", fail_count); end
    endtask

    task automatic test_multi();
        int n = 0;
        wb(5'd5, 32'h1);
        wb(5'd6, 32'h9);
        wb(5'd7, 32'h3);
        cfg(0, 1'b1, 5'd5, 32'h1);
        cfg(1, 1'b1, 5'd6, 32'h2);
        cfg(2, 1'b1, 5'd7, 32'h3);
        start_run(1'b0, 0);
        wait_done(100, n);
        tests++; if (n !== 9) begin failed++; $display("FAIL multi_latency: got %0d want 9", n); end
        tests++; if (fail_count !== 4'd1) begin failed++; $display("FAIL multi_fail_count: got %0d want 1", fail_count); end
        tests++; if (first_fail_idx !== 3'd1) begin failed++; $display("FAIL multi_ff_idx: got %0d want 1", first_fail_idx); end
        tests++; if (first_fail_reg !== 5'd6) begin failed++; $display("FAIL multi_ff_reg: got %0d want 6", first_fail_reg); end
        tests++; if (first_fail_actual !== 32'h9) begin failed++; $display("FAIL multi_ff_actual: got %0h want 9", first_fail_actual); end
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL multi_pass: got %0b want 0", pass); end
        // Second mismatch on x9 (still zero); first-failure capture must stay on idx 1.
        cfg(3, 1'b1, 5'd9, 32'h55);
        n = 0;
        start_run(1'b0, 0);
        wait_done(100, n);
        tests++; if (fail_count !== 4'd2) begin failed++; $display("FAIL multi2_fail_count: got %0d want 2", fail_count); end
        tests++; if (first_fail_idx !== 3'd1) begin failed++; $display("FAIL multi2_ff_idx: got %0d want 1", first_fail_idx); end
        tests++; if (first_fail_actual !== 32'h9) begin failed++; $display("FAIL multi2_ff_actual: got %0h want 9", first_fail_actual); end
    endtask

    task automatic test_x0();
        int n = 0;
        clear_entries();
        wb(5'd0, 32'hFFFF_FFFF);
        cfg(0, 1'b1, 5'd0, 32'h0);
        start_run(1'b0, 1);
        wait_done(100, n);
        tests++; if (n !== 10) begin failed++; $display("FAIL x0_latency: got %0d want 10", n); end
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL x0_pass: got %0b want 1", pass); end
    endtask

    task automatic test_collision();
        int n = 0;
        clear_entries();
        wb(5'd3, 32'hA);
        cfg(0, 1'b1, 5'd3, 32'hA);
        start_run(1'b0, 0);
        tick();
        n = 1;
        // Now in CHECK of idx 0; overwrite x3 on the compare edge.
        wb(5'd3, 32'hB);
        n++;
        wait_done(100, n);
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL collide_pass: got %0b want 1", pass); end
        n = 0;
        start_run(1'b0, 0);
        wait_done(100, n);
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL collide_rerun_pass: got %0b want 0", pass); end
        tests++; if (first_fail_actual !== 32'hB) begin failed++; $display("FAIL collide_rerun_actual: got %0h want b", first_fail_actual); end
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        clear_entries();
        wb(5'd3, 32'h77);
        cfg(0, 1'b1, 5'd3, 32'h77);
        start_run(1'b0, 5);
        tick(); n++;
        cfg(0, 1'b1, 5'd3, 32'hDEAD); n++;
        mode = 1'b1; wait_count = CNT_W'(100); start = 1'b1;
        tick(); n++;
        start = 1'b0;
        wait_done(100, n);
        tests++; if (n !== 14) begin failed++; $display("FAIL busy_ignore_latency: got %0d want 14", n); end
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL busy_ignore_pass: got %0b want 1", pass); end
    endtask

    task automatic test_retire();
        int n = 0;
        clear_entries();
        wb(5'd4, 32'h44);
        cfg(0, 1'b1, 5'd4, 32'h44);
        start_run(1'b1, 4);
        wb(5'd13, 32'h1); n++;
        wb(5'd14, 32'h2); n++;
        wb(5'd15, 32'h3); n++;
        wait_done(1200, n);
        tests++; if (n !== int'(TIMEOUT)) begin failed++; $display("FAIL retire_timeout_latency: got %0d want %0d", n, TIMEOUT); end
        tests++; if (timeout !== 1'b1) begin failed++; $display("FAIL retire_timeout_flag: got %0b want 1", timeout); end
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL retire_timeout_pass: got %0b want 0", pass); end
        n = 0;
        start_run(1'b1, 4);
        wb(5'd0, 32'h5); n++;
        wb(5'd10, 32'h6); n++;
        wb(5'd11, 32'h7); n++;
        wb(5'd12, 32'h8); n++;
        wait_done(1200, n);
        tests++; if (n !== 12) begin failed++; $display("FAIL retire_latency: got %0d want 12", n); end
        tests++; if (timeout !== 1'b0) begin failed++; $display("FAIL retire_no_timeout: got %0b want 0", timeout); end
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL retire_pass: got %0b want 1", pass); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cfg(0, 1'b1, 5'd3, 32'h123);
        start_run(1'b0, 50);
        tick(); tick(); tick();
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL midreset_busy_before: got %0b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy_after: got %0b want 0", busy); end
        start_run(1'b0, 2);
        wait_done(100, n);
        tests++; if (n !== 11) begin failed++; $display("FAIL midreset_latency: got %0d want 11", n); end
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL midreset_pass: got %0b want 1", pass); end
        tests++; if (fail_count !== 4'd0) begin failed++; $display("FAIL midreset_fail_count: got %0d want 0", fail_count); end
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_reg = '0; cfg_val = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; start = 1'b0; mode = 1'b0; wait_count = '0;
        test_reset();
        test_single();
        test_multi();
        test_x0();
        test_collision();
        test_busy_ignore();
        test_retire();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
